// File: rtl/diagonal_to_stream_3d_array.sv
// diagonal_to_stream_3d_array
//   Captures a ROWS x COLS array in one valid/ready handshake, then streams its
//   main diagonal one element per beat. It also reports whether the captured
//   matrix is diagonal (every off-diagonal element is zero) and scalar
//   (diagonal, with all diagonal elements equal).
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in[ROWS][COLS]      input array, BIT_WIDTH bits per element
//   in_valid/in_ready   capture handshake (in_ready is high only in IDLE)
//   out_data/out_index  current diagonal element and its position i
//   out_last            high on the beat where out_index == N-1
//   out_valid/out_ready beat handshake (out_valid is high only in STREAM)
//   is_diagonal         matrix classification, held until the next capture
//   is_scalar           matrix classification, held until the next capture

// Per-row check: every element of this row that is not on the diagonal is zero.
// A row that is at or beyond COLS has no diagonal element, so the whole row
// counts as off-diagonal.
module diagonal_to_stream_row #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8,
  parameter int ROW       = 0
) (
  input  logic [BIT_WIDTH-1:0] row [COLS-1:0],
  output logic                 off_zero
);
  always_comb begin
    off_zero = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (c != ROW && row[c] != '0) off_zero = 1'b0;
  end
endmodule

module diagonal_to_stream_3d_array #(
  parameter  int BIT_WIDTH = 4,
  parameter  int ROWS      = 8,
  parameter  int COLS      = 8,
  localparam int N         = (ROWS < COLS) ? ROWS : COLS,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] in [ROWS-1:0][COLS-1:0],
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]     out_index,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 is_diagonal,
  output logic                 is_scalar
);
  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            idx_nxt;
  logic [N-1:0][BIT_WIDTH-1:0] dbuf;
  logic [N-1:0][BIT_WIDTH-1:0] dcap;
  logic [ROWS-1:0]             row_zero;
  logic                        diag_ok;
  logic                        scal_ok;

  // Classification of the array currently on `in`
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    diagonal_to_stream_row #(.BIT_WIDTH(BIT_WIDTH), .COLS(COLS), .ROW(r)) u_row (
      .row      (in[r]),
      .off_zero (row_zero[r])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_diag
    assign dcap[i] = in[i][i];
  end

  assign diag_ok = &row_zero;

  always_comb begin
    scal_ok = 1'b1;
    for (int i = 1; i < N; i++)
      if (dcap[i] != dcap[0]) scal_ok = 1'b0;
  end

  assign idx_nxt = idx + IDX_W'(1);

  // All outputs are registered. out_data/out_index are loaded one beat ahead,
  // so they keep their last value after the stream returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      dbuf        <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      is_diagonal <= 1'b0;
      is_scalar   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dbuf        <= dcap;
          is_diagonal <= diag_ok;
          is_scalar   <= diag_ok & scal_ok;
          out_data    <= dcap[0];
          out_index   <= '0;
          out_last    <= (N == 1);
          idx         <= '0;
          in_ready    <= 1'b0;
          out_valid   <= 1'b1;
          state       <= STREAM;
        end
        STREAM: if (out_ready) begin
          if (idx == LAST) begin
            // The final beat never overlaps a capture, because in_ready only
            // rises on the following cycle.
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            idx       <= idx_nxt;
            out_data  <= dbuf[idx_nxt];
            out_index <= idx_nxt;
            out_last  <= (idx_nxt == LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_diagonal_to_stream_3d_array.sv
module tb_diagonal_to_stream_3d_array;
  logic clk, rst_n;

  // 8x8 instance
  logic [3:0] m8 [7:0][7:0];
  logic       iv8, ir8, ol8, ov8, or8, dg8, sc8;
  logic [3:0] od8;
  logic [2:0] oi8;

  // 3x5 instance
  logic [3:0] m35 [2:0][4:0];
  logic       iv35, ir35, ol35, ov35, or35, dg35, sc35;
  logic [3:0] od35;
  logic [1:0] oi35;

  int nvec = 0;
  int nbad = 0;

  diagonal_to_stream_3d_array #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in(m8), .in_valid(iv8), .in_ready(ir8),
    .out_data(od8), .out_index(oi8), .out_last(ol8), .out_valid(ov8),
    .out_ready(or8), .is_diagonal(dg8), .is_scalar(sc8));

  diagonal_to_stream_3d_array #(.BIT_WIDTH(4), .ROWS(3), .COLS(5)) d35 (
    .clk(clk), .rst_n(rst_n), .in(m35), .in_valid(iv35), .in_ready(ir35),
    .out_data(od35), .out_index(oi35), .out_last(ol35), .out_valid(ov35),
    .out_ready(or35), .is_diagonal(dg35), .is_scalar(sc35));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d [8];
    int         pr, pc;
    logic [3:0] pv;     // off-diagonal poke value, 0 = none
    bit         ed, es;
    int         stall;  // beat index to stall 3 cycles on, -1 = none
    bit         junk;   // keep in_valid high with another array during STREAM
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill8(input logic [3:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m8[r][c] = v;
  endtask

  task automatic run8(input vec_t v);
    int cnt;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m8[r][c] = (r == c) ? v.d[r] : 4'h0;
    if (v.pv != 4'h0) m8[v.pr][v.pc] = v.pv;
    iv8 = 1'b1;
    step();
    cnt = 1;
    // The captured array must not depend on `in` after the capture edge.
    if (v.junk) fill8(4'h3);
    else begin
      iv8 = 1'b0;
      fill8(4'hF);
    end
    chk("in_ready_stream", ir8, 0);
    for (int i = 0; i < 8; i++) begin
      chk("valid", ov8, 1);
      chk("data", od8, v.d[i]);
      chk("index", oi8, i);
      chk("last", ol8, (i == 7));
      chk("is_diagonal", dg8, v.ed);
      chk("is_scalar", sc8, v.es);
      if (i == v.stall) begin
        or8 = 1'b0;
        repeat (3) begin
          step();
          cnt++;
          chk("stall_valid", ov8, 1);
          chk("stall_data", od8, v.d[i]);
          chk("stall_index", oi8, i);
        end
        or8 = 1'b1;
      end
      step();
      cnt++;
    end
    chk("in_ready_done", ir8, 1);
    chk("valid_done", ov8, 0);
    chk("diag_hold", dg8, v.ed);
    chk("scalar_hold", sc8, v.es);
    chk("cycles", cnt, (v.stall >= 0) ? 12 : 9);
    iv8 = 1'b0;
  endtask

  task automatic run35(input int pr, input int pc, input logic [3:0] pv,
                       input bit ed, input bit es);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) m35[r][c] = (r == c) ? 4'h5 : 4'h0;
    if (pv != 4'h0) m35[pr][pc] = pv;
    iv35 = 1'b1;
    step();
    iv35 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nsq_valid", ov35, 1);
      chk("nsq_data", od35, 4'h5);
      chk("nsq_index", oi35, i);
      chk("nsq_last", ol35, (i == 2));
      chk("nsq_diag", dg35, ed);
      chk("nsq_scalar", sc35, es);
      step();
    end
    chk("nsq_in_ready", ir35, 1);
    chk("nsq_valid_done", ov35, 0);
  endtask

  initial begin
    tv[0] = '{d:'{default:4'hA}, pr:0, pc:0, pv:4'h0, ed:1, es:1, stall:-1, junk:0};
    tv[1] = '{d:'{4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7}, pr:2, pc:5, pv:4'h3,
              ed:0, es:0, stall:-1, junk:0};
    tv[2] = '{d:'{4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7}, pr:0, pc:0, pv:4'h0,
              ed:1, es:0, stall:4, junk:0};
    tv[3] = '{d:'{default:4'h0}, pr:0, pc:0, pv:4'h0, ed:1, es:1, stall:-1, junk:0};
    tv[4] = '{d:'{4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7}, pr:0, pc:0, pv:4'h0,
              ed:1, es:0, stall:-1, junk:1};
    tv[5] = '{d:'{default:4'h5}, pr:7, pc:0, pv:4'h9, ed:0, es:0, stall:-1, junk:1};
    tv[6] = '{d:'{4'h9,4'h9,4'h9,4'h9,4'h9,4'h9,4'h9,4'h8}, pr:0, pc:0, pv:4'h0,
              ed:1, es:0, stall:-1, junk:0};

    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; fill8(4'h0);
    iv35 = 1'b0; or35 = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) m35[r][c] = 4'h0;
    step();
    step();
    chk("rst_in_ready", ir8, 1);
    chk("rst_valid", ov8, 0);
    chk("rst_data", od8, 0);
    chk("rst_index", oi8, 0);
    chk("rst_last", ol8, 0);
    chk("rst_diag", dg8, 0);
    chk("rst_scalar", sc8, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back table run
    for (int k = 0; k < 7; k++) run8(tv[k]);

    // Mid-stream asynchronous reset
    fill8(4'h0);
    for (int i = 0; i < 8; i++) m8[i][i] = 4'hA;
    iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step(); step(); step();
    chk("mid_index", oi8, 3);
    chk("mid_scalar", sc8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov8, 0);
    chk("arst_in_ready", ir8, 1);
    chk("arst_data", od8, 0);
    chk("arst_index", oi8, 0);
    chk("arst_diag", dg8, 0);
    chk("arst_scalar", sc8, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_valid", ov8, 0);
    chk("post_rst_in_ready", ir8, 1);

    // Non-square 3x5
    run35(1, 4, 4'h1, 0, 0);
    run35(0, 0, 4'h0, 1, 1);
    run35(2, 4, 4'h2, 0, 0);   // column beyond the diagonal still counts

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
